// File: rtl/txdata_arbiter.sv
// ============================================================================
//  Module   : txdata_arbiter
//  Purpose  : Round-robin arbiter sharing one hex-word serial transmitter
//             between NCH requesters, each with a one-word holding register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module txdata_arbiter #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int CW  = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NCH-1:0]    i_stb,
    input  logic [NCH*DW-1:0] i_data,
    output logic [NCH-1:0]    o_busy,
    output logic              o_tx_stb,
    output logic [DW-1:0]     o_tx_data,
    output logic [CW-1:0]     o_tx_chan,
    input  logic              i_tx_busy
);

    localparam logic [1:0]    c_IDLE    = 2'd0;
    localparam logic [1:0]    c_ISSUE   = 2'd1;
    localparam logic [1:0]    c_HOLDOFF = 2'd2;
    localparam logic [1:0]    c_DRAIN   = 2'd3;
    localparam logic [CW-1:0] c_LAST    = CW'(NCH - 1);

    logic [1:0]     r_state_q,   w_state_d;
    logic [DW-1:0]  r_hold_q [NCH];
    logic [DW-1:0]  w_hold_d [NCH];
    logic [NCH-1:0] r_pend_q,    w_pend_d;
    logic [CW-1:0]  r_ptr_q,     w_ptr_d;
    logic           r_tx_stb_q,  w_tx_stb_d;
    logic [DW-1:0]  r_tx_data_q, w_tx_data_d;
    logic [CW-1:0]  r_tx_chan_q, w_tx_chan_d;

    logic           w_start;
    logic           w_accept;
    logic [CW-1:0]  w_grant;
    logic [CW-1:0]  w_idx;

    assign w_start  = (r_state_q == c_IDLE) && !i_tx_busy && (|r_pend_q);
    assign w_accept = (r_state_q == c_ISSUE) && !i_tx_busy;

    // Scan from the farthest offset back to ptr so the nearest pending channel wins.
    always_comb begin
        w_grant = r_ptr_q;
        w_idx   = r_ptr_q;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = CW'((int'(r_ptr_q) + i) % NCH);
            if (r_pend_q[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:    if (w_start)    w_state_d = c_ISSUE;
            c_ISSUE:   if (w_accept)   w_state_d = c_HOLDOFF;
            c_HOLDOFF:                 w_state_d = c_DRAIN;
            c_DRAIN:   if (!i_tx_busy) w_state_d = c_IDLE;
            default:                   w_state_d = c_IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        w_pend_d    = r_pend_q;
        w_ptr_d     = r_ptr_q;
        w_tx_stb_d  = r_tx_stb_q;
        w_tx_data_d = r_tx_data_q;
        w_tx_chan_d = r_tx_chan_q;
        for (int k = 0; k < NCH; k++) begin
            w_hold_d[k] = r_hold_q[k];
            if (i_stb[k] && !r_pend_q[k]) begin
                w_hold_d[k] = i_data[k*DW +: DW];
                w_pend_d[k] = 1'b1;
            end
        end
        if (w_start) begin
            w_tx_data_d = r_hold_q[w_grant];
            w_tx_chan_d = w_grant;
            w_tx_stb_d  = 1'b1;
        end
        // A channel is never captured while pending, so this clear cannot collide with a capture.
        if (w_accept) begin
            w_pend_d[r_tx_chan_q] = 1'b0;
            w_ptr_d               = (r_tx_chan_q == c_LAST) ? '0 : r_tx_chan_q + 1'b1;
            w_tx_stb_d            = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_q    <= '0;
            r_ptr_q     <= '0;
            r_tx_stb_q  <= 1'b0;
            r_tx_data_q <= '0;
            r_tx_chan_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_hold_q[k] <= '0;
            end
        end else begin
            r_pend_q    <= w_pend_d;
            r_ptr_q     <= w_ptr_d;
            r_tx_stb_q  <= w_tx_stb_d;
            r_tx_data_q <= w_tx_data_d;
            r_tx_chan_q <= w_tx_chan_d;
            for (int k = 0; k < NCH; k++) begin
                r_hold_q[k] <= w_hold_d[k];
            end
        end
    end

    assign o_busy    = r_pend_q;
    assign o_tx_stb  = r_tx_stb_q;
    assign o_tx_data = r_tx_data_q;
    assign o_tx_chan = r_tx_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_txdata_arbiter.sv
// ============================================================================
//  Module   : tb_txdata_arbiter
//  Purpose  : Directed, table-driven self-checking bench for txdata_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_txdata_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   stb;
    logic [127:0] data;
    logic [3:0]   busy;
    logic         tx_stb;
    logic [31:0]  tx_data;
    logic [1:0]   tx_chan;
    logic         man_busy;
    logic         tx_busy;
    int           busy_cnt;
    int           auto_len;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] word;
    } acc_t;
    acc_t acc_q[$];

    typedef struct {
        logic [3:0]  stb;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  e_busy;
        logic        e_stb;
        logic [31:0] e_data;
        logic [1:0]  e_chan;
    } vec_t;
    vec_t vecs[12];

    txdata_arbiter #(.NCH(4), .DW(32), .CW(2)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_stb     (stb),
        .i_data    (data),
        .o_busy    (busy),
        .o_tx_stb  (tx_stb),
        .o_tx_data (tx_data),
        .o_tx_chan (tx_chan),
        .i_tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for auto_len cycles after each accept
    assign tx_busy = man_busy | (busy_cnt != 0);

    always @(posedge clk) begin
        if (!rst && tx_stb && !tx_busy) begin
            acc_q.push_back('{tx_chan, tx_data});
            busy_cnt <= auto_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (acc_q.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(name, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int   n0;
        logic seen_stb;
        logic found;

        n_checks = 0;
        n_errors = 0;
        busy_cnt = 0;
        auto_len = 0;
        man_busy = 1'b0;
        stb      = '0;
        data     = '0;
        rst      = 1'b1;

        vecs[0]  = '{4'b0100, 32'hDEADBEEF, 1'b0, 4'b0100, 1'b0, 32'h00000000, 2'd0};
        vecs[1]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
        vecs[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
        vecs[3]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
        vecs[4]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
        vecs[5]  = '{4'b0010, 32'h11111111, 1'b0, 4'b0010, 1'b0, 32'hDEADBEEF, 2'd2};
        vecs[6]  = '{4'b0010, 32'h22222222, 1'b0, 4'b0010, 1'b1, 32'h11111111, 2'd1};
        vecs[7]  = '{4'b0010, 32'h22222222, 1'b0, 4'b0000, 1'b0, 32'h11111111, 2'd1};
        vecs[8]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 32'h11111111, 2'd1};
        vecs[9]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 32'h11111111, 2'd1};
        vecs[10] = '{4'b0001, 32'hA5A5A5A5, 1'b1, 4'b0001, 1'b0, 32'h11111111, 2'd1};
        vecs[11] = '{4'b0000, 32'h00000000, 1'b0, 4'b0001, 1'b1, 32'hA5A5A5A5, 2'd0};

        tick();
        tick();
        chk("reset busy",    32'(busy),    32'h0);
        chk("reset tx_stb",  32'(tx_stb),  32'h0);
        chk("reset tx_data", tx_data,      32'h0);
        chk("reset tx_chan", 32'(tx_chan), 32'h0);
        rst = 1'b0;

        // Single channel, busy rejection, and lead-in to the stall
        for (int i = 0; i < 12; i++) begin
            stb      = vecs[i].stb;
            data     = {4{vecs[i].data}};
            man_busy = vecs[i].busy;
            tick();
            chk($sformatf("vec%0d busy", i),    32'(busy),    32'(vecs[i].e_busy));
            chk($sformatf("vec%0d tx_stb", i),  32'(tx_stb),  32'(vecs[i].e_stb));
            chk($sformatf("vec%0d tx_data", i), tx_data,      vecs[i].e_data);
            chk($sformatf("vec%0d tx_chan", i), 32'(tx_chan), 32'(vecs[i].e_chan));
        end
        chk("accepts before stall", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) begin
            chk("first word",  acc_q[0].word, 32'hDEADBEEF);
            chk("second word", acc_q[1].word, 32'h11111111);
        end

        // Stall in ISSUE for 10 cycles
        stb      = '0;
        man_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall%0d tx_stb", i),  32'(tx_stb),  32'h1);
            chk($sformatf("stall%0d tx_data", i), tx_data,      32'hA5A5A5A5);
            chk($sformatf("stall%0d tx_chan", i), 32'(tx_chan), 32'h0);
        end
        chk("no accept during stall", 32'(acc_q.size()), 32'd2);
        man_busy = 1'b0;
        tick();
        chk("stall release tx_stb", 32'(tx_stb), 32'h0);
        chk("stall release busy",   32'(busy),   32'h0);
        chk("stall one accept",     32'(acc_q.size()), 32'd3);
        if (acc_q.size() >= 3) begin
            chk("stall accept word", acc_q[2].word, 32'hA5A5A5A5);
        end

        // Round robin from ptr = 0 with a busy transmitter
        do_reset();
        acc_q.delete();
        auto_len = 5;
        stb  = 4'b1111;
        data = {32'd3, 32'd2, 32'd1, 32'd0};
        tick();
        stb = '0;
        chk("rr all captured", 32'(busy), 32'hF);
        wait_log(4, 200, "rr four grants");
        for (int i = 0; i < 4; i++) begin
            if (acc_q.size() > i) begin
                chk($sformatf("rr grant%0d chan", i), 32'(acc_q[i].chan), 32'(i));
                chk($sformatf("rr grant%0d word", i), acc_q[i].word,      32'(i));
            end
        end
        repeat (12) tick();
        stb  = 4'b1001;
        data = {32'h103, 32'h102, 32'h101, 32'h100};
        tick();
        stb = '0;
        wait_log(6, 200, "rr wrap grants");
        if (acc_q.size() >= 6) begin
            chk("rr wrap first",  32'(acc_q[4].chan), 32'd0);
            chk("rr wrap second", 32'(acc_q[5].chan), 32'd3);
            chk("rr wrap word",   acc_q[5].word,      32'h103);
        end
        repeat (12) tick();

        // Reset during DRAIN with channels 0 and 3 pending
        auto_len = 20;
        n0   = acc_q.size();
        stb  = 4'b0010;
        data = {4{32'hCAFE0001}};
        tick();
        stb = '0;
        wait_log(n0 + 1, 50, "reset-mid first accept");
        stb = 4'b1001;
        tick();
        stb = '0;
        tick();
        tick();
        chk("reset-mid pending", 32'(busy), 32'h9);
        rst = 1'b1;
        tick();
        chk("reset-mid busy",   32'(busy),   32'h0);
        chk("reset-mid tx_stb", 32'(tx_stb), 32'h0);
        rst = 1'b0;
        n0  = acc_q.size();
        seen_stb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_stb) seen_stb = 1'b1;
        end
        chk("reset-mid no strobe", 32'(seen_stb), 32'h0);
        chk("reset-mid no accept", 32'(acc_q.size()), 32'(n0));

        // Fairness: channel 0 hammers, channel 1 strobes once
        do_reset();
        acc_q.delete();
        auto_len = 3;
        data = {32'h0, 32'h0, 32'h0B0B0B0B, 32'h0A0A0A0A};
        stb  = 4'b0001;
        wait_log(1, 50, "fair first grant");
        stb = 4'b0011;
        tick();
        stb = 4'b0001;
        chk("fair ch1 captured", 32'(busy[1]), 32'h1);
        n0 = acc_q.size();
        wait_log(n0 + 2, 100, "fair two grants");
        found = 1'b0;
        for (int i = n0; i < n0 + 2 && i < acc_q.size(); i++) begin
            if (acc_q[i].chan == 2'd1 && acc_q[i].word == 32'h0B0B0B0B) found = 1'b1;
        end
        chk("fair ch1 granted", 32'(found), 32'h1);
        stb = '0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/txdata_arbiter.md
# txdata_arbiter

Round-robin arbiter that shares a single hex-word serial transmitter (the `txdata` word-to-UART stage) between NCH independent requesters. Each requester gets a one-word holding register and its own busy flag. The arbiter sequences one word at a time into the downstream transmitter and waits for the transmitter to drain before issuing the next. It sits between the debug/status sources and the transmitter, so several blocks can print 32-bit words without colliding on the serial line.

## Interface

Parameters:
- NCH, 4: number of requesting channels, 2..8.
- DW, 32: data word width in bits.
- CW, 2: channel-index width in bits, equal to clog2(NCH).

Ports:
- i_clk, input, 1: system clock; all logic is on the rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_stb, input, NCH: per-channel request strobe.
- i_data, input, NCH*DW: per-channel data; channel k occupies bits [k*DW +: DW].
- o_busy, output, NCH: per-channel busy; channel k holds an unsent word.
- o_tx_stb, output, 1: word-valid strobe to the transmitter.
- o_tx_data, output, DW: word presented to the transmitter.
- o_tx_chan, output, CW: index of the channel whose word is on o_tx_data.
- i_tx_busy, input, 1: transmitter busy.

## Operation

Channel capture:
- i_stb[k] && !o_busy[k] → hold[k] <= data slice k, pend[k] <= 1.
- o_busy[k] = pend[k], driven directly from the register.
- i_stb[k] while o_busy[k] is high is ignored. There is no queueing; the requester must retry.
- pend[k] clears on the cycle that channel k's word is accepted downstream.
- A new i_stb[k] on that same accept cycle is ignored, because o_busy[k] is still 1.

State machine (registered):
- IDLE: if !i_tx_busy and any pend is set, choose grant g as the first pending index at or after ptr, searching cyclically modulo NCH. Then load o_tx_data <= hold[g] and o_tx_chan <= g, set o_tx_stb <= 1, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: o_tx_stb is high. o_tx_data and o_tx_chan are stable until acceptance.
  - Acceptance occurs when o_tx_stb && !i_tx_busy.
  - On acceptance: pend[g] <= 0, ptr <= (g+1) mod NCH, o_tx_stb <= 0, go to HOLDOFF.
- HOLDOFF: wait exactly one cycle, then go to DRAIN. This covers the transmitter's one-cycle busy rise.
- DRAIN: stay while i_tx_busy is high; go to IDLE when it is low.

Arbitration and data rules:
- Round-robin fairness: a channel that remains pending is granted within NCH consecutive grants.
- o_tx_data is a plain copy of hold[g]; no arithmetic is applied.
- ptr is CW bits wide and wraps from NCH-1 to 0.

## Timing

- Reset values: o_busy = 0, o_tx_stb = 0, o_tx_data = 0, o_tx_chan = 0, ptr = 0, state = IDLE.
- Reset mid-operation aborts any ISSUE or DRAIN. All pending words are discarded.
- Latency from an idle arbiter with i_tx_busy low:
  - i_stb[k] on cycle 0.
  - o_busy[k] = 1 on cycle 1.
  - o_tx_stb = 1 on cycle 2.
  - If i_tx_busy is low on cycle 2, acceptance occurs on cycle 2 and o_busy[k] = 0 on cycle 3.
- Minimum spacing between two o_tx_stb assertions is 4 cycles: ISSUE, HOLDOFF, DRAIN (1 cycle minimum), IDLE.
- i_tx_busy high during ISSUE stalls the handshake; o_tx_stb and o_tx_data hold unchanged.
- Simultaneous requests on several channels in the same cycle are all captured. They are then served in ptr order.
- An i_stb arriving during DRAIN is captured and arbitrated at the next IDLE.

## Test plan

- Single channel: reset, then i_stb[2] with data 0xDEADBEEF, i_tx_busy tied low.
  - Required: o_busy[2] rises on cycle 1.
  - o_tx_stb = 1 on cycle 2, with o_tx_data = 0xDEADBEEF and o_tx_chan = 2.
  - o_busy[2] = 0 on cycle 3.
- Round-robin: all four channels strobe together with data 0x0, 0x1, 0x2, 0x3; i_tx_busy goes high for 5 cycles after each accept.
  - Required: grants in channel order 0, 1, 2, 3.
  - Then re-strobe channels 3 and 0. Required: 0 is granted before 3, because ptr has wrapped to 0.
- Stall: hold i_tx_busy high for 10 cycles while in ISSUE.
  - Required: o_tx_stb, o_tx_data and o_tx_chan stay stable throughout.
  - Exactly one accept occurs, on the first cycle with i_tx_busy low.
- Busy rejection: i_stb[1] with data 0x11111111, then i_stb[1] with data 0x22222222 while o_busy[1] is high.
  - Required: only 0x11111111 is ever presented.
- Reset mid-operation: assert i_reset in DRAIN with channels 0 and 3 pending.
  - Required: next cycle all o_busy = 0 and o_tx_stb = 0.
  - No further o_tx_stb until a new i_stb.
- Fairness: channel 0 re-strobes continuously and channel 1 strobes once.
  - Required: channel 1 is granted no later than the second grant after its capture.
